clk_div_monitor: RTL and testbench

Downstream consumer of the clock divider output. It samples the divided clock in the `clkin` domain and measures its period and high time in `clkin` cycles. It flags a stalled divider with a timeout. Used for on-chip self-check of divisor programming and for bench/debug readback.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/sync_edge_det.sv | 34 +++
 rtl/clk_div_monitor.sv | 128 ++++++++++++
 tb/tb_clk_div_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
`timescale 1ns / 100ps
// Shared definitions for the clock divider and its on-chip monitor.
//   DefCntW    : default counter / divisor width
//   DefTimeout : default stall limit, in clkin cycles
//   mon_state_e: monitor FSM state encoding
package clk_div_pkg;

  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefTimeout = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StMeas = 2'd2
  } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
`timescale 1ns / 100ps
// Multi-flop synchronizer with rising-edge detector.
//   clkin : sampling clock
//   reset : asynchronous, active-low reset
//   d     : asynchronous input
//   s     : synchronized level (last sync stage)
//   rise  : high for one cycle when s goes 0 -> 1
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
`timescale 1ns / 100ps
// Measures period and high time of a divided clock in clkin cycles and flags a stalled source.
//   clkin     : system clock
//   reset     : asynchronous, active-low reset
//   en        : measurement enable (level)
//   clkdiv_in : divided clock under measurement
//   period    : last rise-to-rise interval
//   high_time : cycles the synced input was high within that interval
//   valid     : one-cycle pulse when period/high_time update
//   timeout   : sticky stall flag, cleared by the next valid or by en=0
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DefCntW,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = DefTimeout
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             clkdiv_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic s, rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clkin(clkin),
    .reset(reset),
    .d    (clkdiv_in),
    .s    (s),
    .rise (rise)
  );

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!en) begin
      state_d   = StIdle;
      cnt_d     = '0;
      hi_d      = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          hi_d    = '0;
          state_d = StArm;
        end
        StArm, StMeas: begin
          // A rise on the same edge that the count hits the limit still commits.
          if (rise) begin
            if (state_q == StMeas) begin
              period_d  = cnt_q;
              high_d    = hi_q;
              valid_d   = 1'b1;
              timeout_d = 1'b0;
            end
            cnt_d   = One;
            hi_d    = One;
            state_d = StMeas;
          end else if (cnt_q == TimeoutVal) begin
            timeout_d = 1'b1;
            period_d  = '0;
            high_d    = '0;
            cnt_d     = '0;
            hi_d      = '0;
            state_d   = StArm;
          end else begin
            cnt_d = cnt_q + One;
            if (state_q == StMeas) begin
              hi_d = hi_q + CNT_W'(s);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
`timescale 1ns / 100ps
// Bench for clk_div_monitor: a behavioural divided-clock source, a reference model that
// derives expected measurements from the raw waveform, and a monitor that pops and compares.
module tb_clk_div_monitor;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT     = 64;

  logic             clkin     = 1'b0;
  logic             reset     = 1'b1;
  logic             en        = 1'b0;
  logic             clkdiv_in = 1'b0;
  logic [CNT_W-1:0] period, high_time;
  logic             valid, timeout;

  clk_div_monitor #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clkin    (clkin),
    .reset    (reset),
    .en       (en),
    .clkdiv_in(clkdiv_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #1 clkin = ~clkin;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Divided-clock source: high for hi_n of every div_n clkin cycles, held low when off.
  int unsigned div_n  = 10;
  int unsigned hi_n   = 5;
  int unsigned phase  = 0;
  bit          src_on = 1'b0;

  always @(negedge clkin) begin
    if (!src_on) begin
      clkdiv_in = 1'b0;
      phase     = 0;
    end else begin
      clkdiv_in = (phase < hi_n);
      phase     = (phase + 1 >= div_n) ? 0 : phase + 1;
    end
  end

  // Reference model: every raw rise closes an interval; it is reported when the monitor was
  // already enabled and tracking at the previous rise and the interval fits in TIMEOUT.
  typedef struct packed {
    int unsigned per;
    int unsigned hi;
  } meas_t;

  meas_t       exp_q[$];
  bit          have_prev = 1'b0;
  bit          last_raw  = 1'b0;
  int unsigned since     = 0;
  int unsigned hcnt      = 0;

  always @(posedge clkin) begin
    if (!reset) begin
      have_prev = 1'b0;
      last_raw  = 1'b0;
    end else begin
      if (clkdiv_in && !last_raw) begin
        if (en && have_prev && since <= TIMEOUT) exp_q.push_back('{per: since, hi: hcnt});
        have_prev = en;
        since     = 1;
        hcnt      = 1;
      end else begin
        if (since < 32'h7fff_ffff) since++;
        hcnt += int'(clkdiv_in);
      end
      if (!en) have_prev = 1'b0;
      last_raw = clkdiv_in;
    end
  end

  // Monitor: compare every valid against the oldest expected measurement.
  int n_valid    = 0;
  bit prev_valid = 1'b0;

  always @(negedge clkin) begin
    meas_t m;
    if (valid) begin
      n_valid++;
      check("valid_spacing", prev_valid, 0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got period=%0d high_time=%0d, expected no valid",
                 period, high_time);
      end else begin
        m = exp_q.pop_front();
        check("period", period, m.per);
        check("high_time", high_time, m.hi);
        check("timeout_at_valid", timeout, 0);
      end
    end
    prev_valid = valid;
  end

  task automatic run(input int unsigned n);
    repeat (n) @(posedge clkin);
    #0.5;
  endtask

  task automatic set_src(input int unsigned d, input int unsigned h);
    div_n = d;
    hi_n  = h;
  endtask

  // Returns just after the first low sample following a high one, far from any rise.
  task automatic wait_fall();
    logic last;
    bit   done = 1'b0;
    int   n    = 0;
    @(posedge clkin);
    last = clkdiv_in;
    while (!done && n < 200) begin
      @(posedge clkin);
      n++;
      if (last && !clkdiv_in) done = 1'b1;
      else last = clkdiv_in;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_fall: no falling edge within 200 cycles, expected one");
    end
    #0.5;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned d;
    int unsigned n;
    bit          seen;

    #0.2 reset = 1'b0;
    #0.3;
    check("reset_period", period, 0);
    check("reset_high_time", high_time, 0);
    check("reset_valid", valid, 0);
    check("reset_timeout", timeout, 0);
    repeat (3) @(posedge clkin);
    #0.5 reset = 1'b1;

    // Divide-by-10, then odd divide-by-7, then 10 -> 4.
    set_src(10, 5);
    src_on = 1'b1;
    wait_fall();
    en = 1'b1;
    run(130);
    set_src(7, 3);
    run(70);
    set_src(10, 5);
    run(50);
    set_src(4, 2);
    run(60);

    for (int i = 0; i < 8; i++) begin
      d = $urandom_range(20, 2);
      set_src(d, $urandom_range(d - 1, 1));
      run($urandom_range(80, 30));
    end

    // Interval equal to the limit still measures; one longer times out.
    set_src(TIMEOUT, TIMEOUT / 2);
    run(3 * TIMEOUT + 10);
    set_src(TIMEOUT + 1, 1);
    run(3 * TIMEOUT);
    set_src(10, 5);
    run(60);

    // Enable gap.
    wait_fall();
    en = 1'b0;
    run(50);
    check("gap_period_hold", period, 10);
    check("gap_high_hold", high_time, 5);
    check("gap_timeout", timeout, 0);
    wait_fall();
    en = 1'b1;
    run(60);

    // Stalled source: one edge to leave IDLE, then cnt counts 0..TIMEOUT before expiring.
    wait_fall();
    en     = 1'b0;
    src_on = 1'b0;
    run(10);
    en   = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4 * TIMEOUT) begin
      @(posedge clkin);
      n++;
      #0.5;
      seen = timeout;
    end
    check("timeout_latency", n, TIMEOUT + 2);
    check("timeout_period", period, 0);
    check("timeout_high_time", high_time, 0);
    src_on = 1'b1;
    run(6);
    check("timeout_sticky_after_first_rise", timeout, 1);
    run(30);
    check("timeout_cleared", timeout, 0);

    // Asynchronous reset mid-measurement.
    wait_fall();
    check("pre_reset_period", period, 10);
    reset = 1'b0;
    #0.2;
    check("async_period", period, 0);
    check("async_high_time", high_time, 0);
    check("async_valid", valid, 0);
    check("async_timeout", timeout, 0);
    repeat (3) @(posedge clkin);
    #0.5 reset = 1'b1;
    run(80);

    run(20);
    check("queue_drained", exp_q.size(), 0);
    check("enough_valids", n_valid >= 40, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
